// File: rtl/demux3_8_registrado_pkg.sv
// -----------------------------------------------------------------------------
// demux3_8_registrado_pkg
// Shared constants and helpers for the registered 1:3 demultiplexer.
//   LARGURA     : data width of the input word and every output channel
//   NUM_CANAIS  : number of output channels
//   CONT_W      : width of the per-channel delivery counters
//   SEL_ILEGAL  : Controle code that addresses no channel
//   decodifica(): Controle -> one-hot channel mask (zero for the illegal code)
// -----------------------------------------------------------------------------
package demux3_8_registrado_pkg;

    localparam int LARGURA    = 8;
    localparam int NUM_CANAIS = 3;
    localparam int CONT_W     = 8;

    localparam logic [1:0] SEL_ILEGAL = 2'b11;

    typedef enum logic [1:0] {
        SEL_CANAL0 = 2'b00,
        SEL_CANAL1 = 2'b01,
        SEL_CANAL2 = 2'b10,
        SEL_ERRO   = 2'b11
    } sel_e;

    // One-hot destination mask; the illegal code selects nothing.
    function automatic logic [NUM_CANAIS-1:0] decodifica(input logic [1:0] sel);
        logic [NUM_CANAIS-1:0] mascara;
        case (sel_e'(sel))
            SEL_CANAL0: mascara = 3'b001;
            SEL_CANAL1: mascara = 3'b010;
            SEL_CANAL2: mascara = 3'b100;
            default:    mascara = 3'b000;
        endcase
        return mascara;
    endfunction

endpackage

// File: rtl/demux3_8_registrado_if.sv
// -----------------------------------------------------------------------------
// demux3_8_registrado_if
// Producer/consumer bus of the registered 1:3 demultiplexer.
//   Entrada, Controle, EntradaValida : producer word, destination, valid
//   EntradaPronta                    : block accepts the word this cycle
//   Saida0..2, SaidaValida           : registered channel words and valids
//   SaidaPronta                      : per-channel consumer ready
//   Contagem0..2                     : words delivered per channel
//   Erro                             : sticky illegal-select flag
// master = producer/consumer side, slave = the demultiplexer.
// -----------------------------------------------------------------------------
interface demux3_8_registrado_if;
    import demux3_8_registrado_pkg::*;

    logic [LARGURA-1:0]    Entrada;
    logic [1:0]            Controle;
    logic                  EntradaValida;
    logic                  EntradaPronta;
    logic [LARGURA-1:0]    Saida0;
    logic [LARGURA-1:0]    Saida1;
    logic [LARGURA-1:0]    Saida2;
    logic [NUM_CANAIS-1:0] SaidaValida;
    logic [NUM_CANAIS-1:0] SaidaPronta;
    logic [CONT_W-1:0]     Contagem0;
    logic [CONT_W-1:0]     Contagem1;
    logic [CONT_W-1:0]     Contagem2;
    logic                  Erro;

    modport master (
        output Entrada, Controle, EntradaValida, SaidaPronta,
        input  EntradaPronta, Saida0, Saida1, Saida2, SaidaValida,
        input  Contagem0, Contagem1, Contagem2, Erro
    );

    modport slave (
        input  Entrada, Controle, EntradaValida, SaidaPronta,
        output EntradaPronta, Saida0, Saida1, Saida2, SaidaValida,
        output Contagem0, Contagem1, Contagem2, Erro
    );

endinterface

// File: rtl/demux3_8_registrado_canal_saida.sv
// -----------------------------------------------------------------------------
// canal_saida
// One output channel: a single registered word with valid/ready and a
// delivery counter.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_carga        : accepted word addressed to this channel (load o_dado)
//   i_dado         : word to load
//   i_pronta       : consumer takes o_dado this cycle
//   o_dado         : held word (keeps its last value after draining)
//   o_valida       : o_dado holds an undelivered word
//   o_contagem     : number of drains, wraps at 2**CONT_W
//   o_livre        : slot can take a word this cycle (empty or draining now)
// -----------------------------------------------------------------------------
module canal_saida
    import demux3_8_registrado_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_carga,
    input  logic [LARGURA-1:0] i_dado,
    input  logic               i_pronta,
    output logic [LARGURA-1:0] o_dado,
    output logic               o_valida,
    output logic [CONT_W-1:0]  o_contagem,
    output logic               o_livre
);

    logic [LARGURA-1:0] r_dado;
    logic               r_valida;
    logic [CONT_W-1:0]  r_contagem;
    logic               w_dreno;

    // Ready on a held word is only meaningful while the slot is full.
    assign w_dreno = r_valida & i_pronta;
    assign o_livre = ~r_valida | i_pronta;

    // Data/valid slot: a load wins over a drain so back-to-back words never bubble.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dado   <= {LARGURA{1'b0}};
            r_valida <= 1'b0;
        end else if (i_carga) begin
            r_dado   <= i_dado;
            r_valida <= 1'b1;
        end else if (w_dreno) begin
            r_dado   <= r_dado;
            r_valida <= 1'b0;
        end else begin
            r_dado   <= r_dado;
            r_valida <= r_valida;
        end
    end

    // Delivery counter, free-running wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_contagem <= {CONT_W{1'b0}};
        end else if (w_dreno) begin
            r_contagem <= r_contagem + {{(CONT_W-1){1'b0}}, 1'b1};
        end else begin
            r_contagem <= r_contagem;
        end
    end

    assign o_dado     = r_dado;
    assign o_valida   = r_valida;
    assign o_contagem = r_contagem;

endmodule

// File: rtl/demux3_8_registrado.sv
// -----------------------------------------------------------------------------
// demux3_8_registrado
// Routes one producer word to one of three registered consumer channels.
// A stalled channel only blocks words addressed to it; the illegal select
// is always accepted, dropped, and latched into the sticky Erro flag.
//   Clock  : rising-edge clock
//   Resetn : asynchronous active-low reset
//   bus    : producer/consumer bus (slave side), see demux3_8_registrado_if
// -----------------------------------------------------------------------------
module demux3_8_registrado
    import demux3_8_registrado_pkg::*;
(
    input  logic                  Clock,
    input  logic                  Resetn,
    demux3_8_registrado_if.slave  bus
);

    logic [NUM_CANAIS-1:0] w_sel_oh;
    logic                  w_ilegal;
    logic                  w_pronta;
    logic                  w_aceita;
    logic [NUM_CANAIS-1:0] w_carga;
    logic [NUM_CANAIS-1:0] w_livre;
    logic [NUM_CANAIS-1:0] w_valida;
    logic [LARGURA-1:0]    w_saida    [NUM_CANAIS];
    logic [CONT_W-1:0]     w_contagem [NUM_CANAIS];
    logic                  r_erro;

    assign w_sel_oh = decodifica(bus.Controle);
    assign w_ilegal = (bus.Controle == SEL_ILEGAL);

    // Ready depends only on the addressed channel; illegal words are always taken.
    always_comb begin
        w_pronta = 1'b0;
        if (w_ilegal) begin
            w_pronta = 1'b1;
        end else begin
            w_pronta = |(w_sel_oh & w_livre);
        end
    end

    assign w_aceita = bus.EntradaValida & w_pronta;
    assign w_carga  = w_sel_oh & {NUM_CANAIS{w_aceita}};

    genvar n;
    generate
        for (n = 0; n < NUM_CANAIS; n++) begin : g_canal
            canal_saida u_canal (
                .i_clk      (Clock),
                .i_rst_n    (Resetn),
                .i_carga    (w_carga[n]),
                .i_dado     (bus.Entrada),
                .i_pronta   (bus.SaidaPronta[n]),
                .o_dado     (w_saida[n]),
                .o_valida   (w_valida[n]),
                .o_contagem (w_contagem[n]),
                .o_livre    (w_livre[n])
            );
        end
    endgenerate

    // Sticky illegal-select flag, cleared only by reset.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_erro <= 1'b0;
        end else if (w_aceita && w_ilegal) begin
            r_erro <= 1'b1;
        end else begin
            r_erro <= r_erro;
        end
    end

    assign bus.EntradaPronta = w_pronta;
    assign bus.Saida0        = w_saida[0];
    assign bus.Saida1        = w_saida[1];
    assign bus.Saida2        = w_saida[2];
    assign bus.SaidaValida   = w_valida;
    assign bus.Contagem0     = w_contagem[0];
    assign bus.Contagem1     = w_contagem[1];
    assign bus.Contagem2     = w_contagem[2];
    assign bus.Erro          = r_erro;

endmodule
